// File: rtl/pc_sequencer.sv
// Program counter sequencer: holds PC, forms PC+2 and jump/branch/call/return
// targets, and keeps a small circular return-address stack.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic [2:0]  jb_op,
  input  logic [11:0] imm,
  input  logic [15:0] jump_addr,
  input  logic        flag_z,
  input  logic        flag_n,
  output logic [15:0] pc,
  output logic [15:0] pc2_inst,
  output logic [15:0] jb_inst,
  output logic        jbp_enable,
  output logic [4:0]  ras_depth,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int         PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [4:0] DEPTH_MAX = 5'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JUMP = 3'd1,
    OP_BZ   = 3'd2,
    OP_BNZ  = 3'd3,
    OP_BN   = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } jb_op_t;

  // imm is a signed word offset; scale to bytes and add with silent wrap.
  function automatic logic [15:0] branch_target(input logic [15:0] base,
                                                input logic [11:0] ofs);
    logic signed [15:0] byte_ofs;
    byte_ofs = $signed({{3{ofs[11]}}, ofs, 1'b0});
    return base + $unsigned(byte_ofs);
  endfunction

  logic [15:0]      ras [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [15:0]      ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             adv;
  logic             do_call;
  logic             do_ret;
  jb_op_t           op;

  assign op        = jb_op_t'(jb_op);
  assign adv       = instr_valid & ~stall;
  assign pc2_inst  = pc + 16'd2;
  assign top_ptr   = ras_ptr - PTR_W'(1);
  assign ras_top   = ras[top_ptr];
  assign ras_empty = (ras_depth == 5'd0);
  assign ras_full  = (ras_depth == DEPTH_MAX);
  assign do_call   = adv & (op == OP_CALL);
  assign do_ret    = adv & (op == OP_RET);

  always_comb begin
    jb_inst    = pc2_inst;
    jbp_enable = 1'b0;
    case (op)
      OP_JUMP: begin
        jb_inst    = {jump_addr[15:1], 1'b0};
        jbp_enable = 1'b1;
      end
      OP_BZ: begin
        jb_inst    = branch_target(pc2_inst, imm);
        jbp_enable = flag_z;
      end
      OP_BNZ: begin
        jb_inst    = branch_target(pc2_inst, imm);
        jbp_enable = ~flag_z;
      end
      OP_BN: begin
        jb_inst    = branch_target(pc2_inst, imm);
        jbp_enable = flag_n;
      end
      OP_CALL: begin
        jb_inst    = branch_target(pc2_inst, imm);
        jbp_enable = 1'b1;
      end
      OP_RET: begin
        if (!ras_empty) begin
          jb_inst    = ras_top;
          jbp_enable = 1'b1;
        end
      end
      default: begin
        jb_inst    = pc2_inst;
        jbp_enable = 1'b0;
      end
    endcase
  end

  // Control state: PC, stack pointer, depth and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ras_ptr       <= '0;
      ras_depth     <= 5'd0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (adv) begin
      pc <= jbp_enable ? jb_inst : pc2_inst;
      if (do_call) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_full) ras_overflow <= 1'b1;
        else          ras_depth    <= ras_depth + 5'd1;
      end
      if (do_ret) begin
        if (!ras_empty) begin
          ras_ptr   <= top_ptr;
          ras_depth <= ras_depth - 5'd1;
        end else begin
          ras_underflow <= 1'b1;
        end
      end
    end
  end

  // Stack storage is data only; when full the write slot is the oldest entry.
  always_ff @(posedge clk) begin
    if (rst_n && do_call) ras[ras_ptr] <= pc2_inst;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        stall;
  logic [2:0]  jb_op;
  logic [11:0] imm;
  logic [15:0] jump_addr;
  logic        flag_z;
  logic        flag_n;
  logic [15:0] pc;
  logic [15:0] pc2_inst;
  logic [15:0] jb_inst;
  logic        jbp_enable;
  logic [4:0]  ras_depth;
  logic        ras_overflow;
  logic        ras_underflow;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
    .jb_op(jb_op), .imm(imm), .jump_addr(jump_addr), .flag_z(flag_z),
    .flag_n(flag_n), .pc(pc), .pc2_inst(pc2_inst), .jb_inst(jb_inst),
    .jbp_enable(jbp_enable), .ras_depth(ras_depth),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] addr);
    jb_op = 3'd1; jump_addr = addr; stall = 1'b0; instr_valid = 1'b1;
    step();
  endtask

  task automatic flags(input logic [4:0] d, input logic ov, input logic un, input string tag);
    check({tag, "_depth"}, 16'(ras_depth), 16'(d));
    check({tag, "_ovf"}, 16'(ras_overflow), 16'(ov));
    check({tag, "_unf"}, 16'(ras_underflow), 16'(un));
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; jb_op = 3'd0;
    imm = 12'h000; jump_addr = 16'h0000; flag_z = 1'b0; flag_n = 1'b0;
    step();
    check("reset_pc", pc, 16'h0000);
    flags(5'd0, 1'b0, 1'b0, "reset");

    // Sequential run
    rst_n = 1'b1; instr_valid = 1'b1; jb_op = 3'd0;
    #1;
    check("seq_pc2", pc2_inst, 16'h0002);
    check("seq_jbp", 16'(jbp_enable), 16'h0);
    step(); check("seq_pc1", pc, 16'h0002);
    step(); check("seq_pc2r", pc, 16'h0004);
    step(); check("seq_pc3", pc, 16'h0006);
    flags(5'd0, 1'b0, 1'b0, "seq");

    // Instruction not valid holds PC
    instr_valid = 1'b0;
    step(); check("hold_invalid", pc, 16'h0006);
    instr_valid = 1'b1;

    // Branch if Z, taken and not taken
    jump_to(16'h0010);
    check("jump_0010", pc, 16'h0010);
    jb_op = 3'd2; imm = 12'hFFC; flag_z = 1'b1; #1;
    check("bz_target", jb_inst, 16'h000A);
    check("bz_taken_jbp", 16'(jbp_enable), 16'h1);
    step(); check("bz_taken_pc", pc, 16'h000A);
    jump_to(16'h0010);
    jb_op = 3'd2; imm = 12'hFFC; flag_z = 1'b0; #1;
    check("bz_nt_jbp", 16'(jbp_enable), 16'h0);
    step(); check("bz_nt_pc", pc, 16'h0012);

    // Branch if !Z, branch if N, reserved op
    jb_op = 3'd3; flag_z = 1'b1; #1;
    check("bnz_nt_jbp", 16'(jbp_enable), 16'h0);
    jb_op = 3'd4; imm = 12'h002; flag_n = 1'b1; #1;
    check("bn_target", jb_inst, 16'h0018);
    check("bn_jbp", 16'(jbp_enable), 16'h1);
    step(); check("bn_pc", pc, 16'h0018);
    jb_op = 3'd7; flag_n = 1'b0; #1;
    check("rsvd_jbp", 16'(jbp_enable), 16'h0);
    check("rsvd_jb", jb_inst, 16'h001A);

    // Jump under stall
    jb_op = 3'd1; jump_addr = 16'h1235; stall = 1'b1; #1;
    check("jmp_target", jb_inst, 16'h1234);
    check("jmp_jbp_stall", 16'(jbp_enable), 16'h1);
    step(); check("stall_pc1", pc, 16'h0018);
    step(); check("stall_pc2", pc, 16'h0018);
    stall = 1'b0;
    step(); check("jmp_pc", pc, 16'h1234);

    // Call and return
    jump_to(16'h0100);
    jb_op = 3'd5; imm = 12'h010; #1;
    check("call_target", jb_inst, 16'h0122);
    step(); check("call_pc", pc, 16'h0122);
    flags(5'd1, 1'b0, 1'b0, "call");
    jb_op = 3'd6; #1;
    check("ret_target", jb_inst, 16'h0102);
    check("ret_jbp", 16'(jbp_enable), 16'h1);
    step(); check("ret_pc", pc, 16'h0102);
    check("ret_depth", 16'(ras_depth), 16'd0);

    // Stalled call must not push
    jb_op = 3'd5; imm = 12'h000; stall = 1'b1;
    step(); check("stall_call_depth", 16'(ras_depth), 16'd0);
    check("stall_call_pc", pc, 16'h0102);
    stall = 1'b0;

    // Five calls with zero offset: pushes 0104,0106,0108,010A then 010C over 0104
    for (int i = 0; i < 4; i++) step();
    check("fill_pc", pc, 16'h010A);
    flags(5'd4, 1'b0, 1'b0, "fill");
    step();
    check("ovf_pc", pc, 16'h010C);
    flags(5'd4, 1'b1, 1'b0, "ovf");

    // Five returns: 010C,010A,0108,0106 then fall through
    jb_op = 3'd6; #1;
    check("pop1_jb", jb_inst, 16'h010C); step();
    check("pop2_jb", jb_inst, 16'h010A); step();
    check("pop3_jb", jb_inst, 16'h0108); step();
    check("pop4_jb", jb_inst, 16'h0106); step();
    check("pop4_pc", pc, 16'h0106);
    flags(5'd0, 1'b1, 1'b0, "pop4");
    check("unf_jbp", 16'(jbp_enable), 16'h0);
    check("unf_jb", jb_inst, 16'h0108);
    step();
    check("unf_pc", pc, 16'h0108);
    flags(5'd0, 1'b1, 1'b1, "unf");

    // Wrap-around of PC and branch target
    jump_to(16'hFFFF);
    check("wrap_jump_pc", pc, 16'hFFFE);
    jb_op = 3'd2; imm = 12'h002; flag_z = 1'b1; #1;
    check("wrap_br_target", jb_inst, 16'h0004);
    jb_op = 3'd0; #1;
    check("wrap_pc2", pc2_inst, 16'h0000);
    step(); check("wrap_pc", pc, 16'h0000);

    // Reset in the middle of a call
    jb_op = 3'd5; imm = 12'h000;
    step(); step();
    check("pre_rst_pc", pc, 16'h0004);
    flags(5'd2, 1'b1, 1'b1, "pre_rst");
    rst_n = 1'b0;
    step();
    check("midrst_pc", pc, 16'h0000);
    flags(5'd0, 1'b0, 1'b0, "midrst");
    rst_n = 1'b1; jb_op = 3'd6; #1;
    check("post_rst_jbp", 16'(jbp_enable), 16'h0);
    step();
    check("post_rst_pc", pc, 16'h0002);
    flags(5'd0, 1'b0, 1'b1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
